// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the audio path blocks (sine source, codec
// config, I2S serializer).
//   DEF_SAMPLE_W : default sample width.
//   state_t      : serializer FSM states.
//   vol_atten()  : volume attenuation, arithmetic right shift by 2*volume.
package audio_pkg;

    localparam int DEF_SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } state_t;

    // Works on a 32-bit container so every block can share it whatever its
    // sample width (up to 32). The caller sign-extends in and truncates out.
    function automatic logic signed [31:0] vol_atten(input logic signed [31:0] sample,
                                                     input logic [1:0]         volume);
        return sample >>> {volume, 1'b0};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous level, followed by a
// registered copy used to produce one-cycle edge strobes.
//   clk, reset : system clock, async active-high reset
//   din        : asynchronous input level
//   rise, fall : one-clk strobes, valid 2 cycles after the pin edge is sampled
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    // Strobes are decoded from registered state so the consumer's register
    // update lands on the third clk edge after the pin changes.
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: mono I2S serializer toward the WM8731 DAC. The codec is bit- and
// LR-clock master; both clocks are sampled in the clk domain. One attenuated
// sample is latched per frame (at the left-channel LR fall) and sent MSB-first
// in both the left and right slots.
//   clk, reset  : system clock, async active-high reset
//   enable      : codec configured; idle while low
//   bclk        : codec bit clock (async)
//   dac_lr_clk  : codec LR clock (async), low = left, high = right
//   volume      : attenuation, sample >>> (2*volume), sampled at LR fall
//   data_in     : signed sample from upstream
//   data_ready  : one-clk pulse asking upstream for the next sample
//   dac_dat     : serial data to the codec
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                bclk,
    input  logic                dac_lr_clk,
    input  logic [1:0]          volume,
    input  logic [SAMPLE_W-1:0] data_in,
    output logic                data_ready,
    output logic                dac_dat
);

    localparam int CNT_W = $clog2(SAMPLE_W) + 1;

    logic bclk_fall, bclk_rise_unused;
    logic lr_fall, lr_rise;

    sync_edge u_bclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bclk),
        .rise  (bclk_rise_unused),
        .fall  (bclk_fall)
    );

    sync_edge u_lr_sync (
        .clk   (clk),
        .reset (reset),
        .din   (dac_lr_clk),
        .rise  (lr_rise),
        .fall  (lr_fall)
    );

    state_t              state, state_n;
    logic [SAMPLE_W-1:0] hold, hold_n;
    logic [SAMPLE_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]    bitcnt, bitcnt_n;
    logic                dac_dat_n;
    logic                data_ready_n;
    logic [SAMPLE_W-1:0] atten;

    assign atten = SAMPLE_W'(vol_atten(32'(signed'(data_in)), volume));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            dac_dat    <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            dac_dat    <= dac_dat_n;
            data_ready <= data_ready_n;
        end
    end

    always_comb begin
        state_n      = state;
        hold_n       = hold;
        shreg_n      = shreg;
        bitcnt_n     = bitcnt;
        dac_dat_n    = dac_dat;
        data_ready_n = 1'b0;

        if (!enable) begin
            state_n   = IDLE;
            dac_dat_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    dac_dat_n = 1'b0;
                    state_n   = WAIT;
                end

                WAIT: begin
                    dac_dat_n = 1'b0;
                    // Frame alignment: only a left-channel start is a valid
                    // entry point, a right-channel edge is ignored here.
                    if (lr_fall) begin
                        hold_n       = atten;
                        shreg_n      = atten;
                        bitcnt_n     = '0;
                        data_ready_n = 1'b1;
                        state_n      = SHIFT;
                    end
                end

                SHIFT, PAD: begin
                    // LR edges take priority over a coincident bclk fall, so
                    // the MSB goes out on the bclk fall after the LR change.
                    if (lr_fall) begin
                        hold_n       = atten;
                        shreg_n      = atten;
                        bitcnt_n     = '0;
                        data_ready_n = 1'b1;
                        state_n      = SHIFT;
                    end else if (lr_rise) begin
                        shreg_n  = hold;
                        bitcnt_n = '0;
                        state_n  = SHIFT;
                    end else if (bclk_fall) begin
                        if (state == SHIFT) begin
                            dac_dat_n = shreg[SAMPLE_W-1];
                            shreg_n   = {shreg[SAMPLE_W-2:0], 1'b0};
                            bitcnt_n  = bitcnt + CNT_W'(1);
                            if (bitcnt_n == CNT_W'(SAMPLE_W))
                                state_n = PAD;
                        end else begin
                            dac_dat_n = 1'b0;
                        end
                    end
                end

                default: begin
                    state_n   = IDLE;
                    dac_dat_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a codec model drives bclk/LR with 64 bclk per frame
// and pushes the expected dac_dat value for each bit slot into a queue; a
// monitor pops and compares at every bclk rise (mid-bit). data_ready pulses
// are counted separately and checked at section boundaries.
module tb_i2s_dac_tx;
    import audio_pkg::*;

    localparam int HALF = 5;   // bclk half-period in clk cycles

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        bclk;
    logic        dac_lr_clk;
    logic [1:0]  volume;
    logic [15:0] data_in;
    logic        data_ready;
    logic        dac_dat;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int dr_count = 0;
    logic dr_prev = 1'b0;

    i2s_dac_tx #(.SAMPLE_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bclk       (bclk),
        .dac_lr_clk (dac_lr_clk),
        .volume     (volume),
        .data_in    (data_in),
        .data_ready (data_ready),
        .dac_dat    (dac_dat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: dac_dat is stable mid-bit, 2 clk after it updates.
    always @(posedge bclk) begin
        if (exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            if (e >= 0) begin
                tests++;
                if (dac_dat !== e[0]) begin
                    fails++;
                    $display("FAIL dac_dat bit @%0t: got %b expected %0d", $time, dac_dat, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            dr_count++;
            tests++;
            if (dr_prev) begin
                fails++;
                $display("FAIL data_ready width @%0t: got 2+ cycles expected 1", $time);
            end
        end
        dr_prev = data_ready;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Bit periods k0..k1 of one LR half-frame; LR changes on the k=0 bclk fall.
    // Slot 0 is the reload cycle (don't care), slots 1..16 carry word MSB first.
    task automatic half_frame(input logic lr, input logic [15:0] word,
                              input int k0, input int k1, input bit en);
        for (int k = k0; k <= k1; k++) begin
            int e;
            if (!en)          e = 0;
            else if (k == 0)  e = -1;
            else if (k <= 16) e = int'(word[16-k]);
            else              e = 0;
            bclk = 1'b0;
            if (k == 0) dac_lr_clk = lr;
            exp_q.push_back(e);
            wait_clk(HALF);
            bclk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic frame(input logic [15:0] word, input bit en);
        half_frame(1'b0, word, 0, 31, en);
        half_frame(1'b1, word, 0, 31, en);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        bclk       = 1'b1;
        dac_lr_clk = 1'b1;
        volume     = 2'd0;
        data_in    = 16'h0000;
        wait_clk(3);
        check("reset dac_dat", 32'(dac_dat), 32'd0);
        check("reset data_ready", 32'(data_ready), 32'd0);
        check("reset state", 32'(dut.state), 32'(IDLE));
        check("reset hold", 32'(dut.hold), 32'd0);

        // Basic pattern, both slots carry the same word.
        reset   = 1'b0;
        enable  = 1'b1;
        data_in = 16'hA5F0;
        half_frame(1'b1, 16'h0000, 0, 31, 1'b0);
        frame(16'hA5F0, 1'b1);
        check("dr after first frame", dr_count, 1);

        // Attenuation.
        data_in = 16'h8000; volume = 2'd1;
        frame(16'hE000, 1'b1);
        data_in = 16'h7FFF; volume = 2'd3;
        frame(16'h01FF, 1'b1);
        check("dr after volume frames", dr_count, 3);

        // Volume change mid-word only hits the next frame.
        data_in = 16'hA5F0; volume = 2'd0;
        half_frame(1'b0, 16'hA5F0, 0, 7, 1'b1);
        volume = 2'd2;
        half_frame(1'b0, 16'hA5F0, 8, 31, 1'b1);
        half_frame(1'b1, 16'hA5F0, 0, 31, 1'b1);
        frame(16'hFA5F, 1'b1);
        check("dr after mid-word volume", dr_count, 5);

        // Disabled for 3 frames, re-enabled mid-frame.
        enable = 1'b0;
        repeat (3) frame(16'hFFFF, 1'b0);
        check("dr while disabled", dr_count, 5);
        half_frame(1'b0, 16'h0000, 0, 9, 1'b0);
        enable = 1'b1;
        half_frame(1'b0, 16'h0000, 10, 31, 1'b0);
        half_frame(1'b1, 16'h0000, 0, 31, 1'b0);
        data_in = 16'h3C5A; volume = 2'd0;
        frame(16'h3C5A, 1'b1);
        check("dr after re-enable", dr_count, 6);

        // Short left half: LR rises after 10 bclk falls.
        data_in = 16'hC3A5;
        half_frame(1'b0, 16'hC3A5, 0, 10, 1'b1);
        half_frame(1'b1, 16'hC3A5, 0, 31, 1'b1);
        check("dr after short frame", dr_count, 7);
        data_in = 16'h0F0F;
        frame(16'h0F0F, 1'b1);
        check("dr after recovery frame", dr_count, 8);

        // Reset while bit 8 (a one) of A5F0 is on the wire.
        data_in = 16'hA5F0;
        half_frame(1'b0, 16'hA5F0, 0, 8, 1'b1);
        reset = 1'b1;
        #1;
        check("async reset dac_dat", 32'(dac_dat), 32'd0);
        check("async reset state", 32'(dut.state), 32'(IDLE));
        half_frame(1'b0, 16'h0000, 9, 9, 1'b0);
        reset = 1'b0;
        half_frame(1'b0, 16'h0000, 10, 31, 1'b0);
        half_frame(1'b1, 16'h0000, 0, 31, 1'b0);
        check("dr after reset frame", dr_count, 9);
        frame(16'hA5F0, 1'b1);
        check("dr after post-reset frame", dr_count, 10);

        wait_clk(10);
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
